// File: rtl/vec_mem_lsu_if.sv
// Bundles the vec_mem_lsu request, store-data, response and data_mem_vect ports.
// The slave modport is the LSU's view; the master modport is the pipeline/memory side.
interface vec_mem_lsu_if #(
   parameter int LANES = 6,
   parameter int EW    = 8,
   parameter int CNT_W = 4
);
   logic                   req_valid;
   logic                   req_ready;
   logic                   req_we;
   logic [31:0]            req_addr;
   logic [31:0]            req_stride;
   logic [CNT_W-1:0]       req_count;
   logic                   st_valid;
   logic                   st_ready;
   logic [LANES*EW-1:0]    st_data;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [LANES*EW-1:0]    rsp_rdata;
   logic                   rsp_last;
   logic                   rsp_err;
   logic                   mem_WE;
   logic [31:0]            mem_A;
   logic [LANES*EW-1:0]    mem_WD;
   logic [LANES*EW-1:0]    mem_RD;

   modport slave (
      input  req_valid, req_we, req_addr, req_stride, req_count,
      input  st_valid, st_data, rsp_ready, mem_RD,
      output req_ready, st_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
      output mem_WE, mem_A, mem_WD
   );

   modport master (
      output req_valid, req_we, req_addr, req_stride, req_count,
      output st_valid, st_data, rsp_ready, mem_RD,
      input  req_ready, st_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
      input  mem_WE, mem_A, mem_WD
   );
endinterface

// File: rtl/vec_mem_lsu.sv
// Vector load/store burst sequencer driving data_mem_vect, one beat per cycle.
// Optional bounds check: define VEC_MEM_LSU_BOUNDS_CHECK_EN (enables MEM_BYTES).
module vec_mem_lsu #(
   parameter int LANES     = 6,
   parameter int EW        = 8,
`ifdef VEC_MEM_LSU_BOUNDS_CHECK_EN
   parameter int CNT_W     = 4,
   parameter int MEM_BYTES = 1024
`else
   parameter int CNT_W     = 4
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   vec_mem_lsu_if.slave  bus
);
   localparam int DW = LANES * EW;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_STORE = 2'd2;
   localparam logic [1:0] S_ACK   = 2'd3;

   logic [1:0]       state_r;
   logic [31:0]      cur_addr_r;
   logic [31:0]      stride_r;
   logic [CNT_W-1:0] rem_r;
   logic             err_sticky_r;

   logic             rsp_valid_r;
   logic [DW-1:0]    rsp_rdata_r;
   logic             rsp_last_r;
   logic             rsp_err_r;

   logic             rsp_free_s;
   logic             req_fire_s;
   logic             ld_beat_s;
   logic             st_beat_s;
   logic             ack_fire_s;
   logic             last_s;
   logic             oob_s;

`ifdef VEC_MEM_LSU_BOUNDS_CHECK_EN
   assign oob_s = (cur_addr_r >= 32'(MEM_BYTES));
`else
   assign oob_s = 1'b0;
`endif

   // Handshake and beat qualifiers
   always_comb begin
      rsp_free_s = !rsp_valid_r || bus.rsp_ready;
      req_fire_s = (state_r == S_IDLE) && !rsp_valid_r && bus.req_valid;
      ld_beat_s  = (state_r == S_LOAD) && rsp_free_s;
      st_beat_s  = (state_r == S_STORE) && bus.st_valid;
      ack_fire_s = (state_r == S_ACK) && rsp_free_s;
      last_s     = (rem_r == CNT_W'(1));
   end

   // Memory port and ready outputs decoded from state so reset clears them at once
   always_comb begin
      bus.mem_WE    = 1'b0;
      bus.mem_A     = 32'h0000_0000;
      bus.mem_WD    = '0;
      bus.req_ready = 1'b0;
      bus.st_ready  = 1'b0;
      case (state_r)
         S_IDLE: begin
            bus.req_ready = !rsp_valid_r;
         end
         S_LOAD: begin
            bus.mem_A = cur_addr_r;
         end
         S_STORE: begin
            bus.mem_A    = cur_addr_r;
            bus.mem_WD   = bus.st_data;
            bus.mem_WE   = st_beat_s && !oob_s;
            bus.st_ready = 1'b1;
         end
         S_ACK: begin
            bus.mem_A = 32'h0000_0000;
         end
         default: begin
            bus.mem_WE = 1'b0;
         end
      endcase
   end

   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_rdata = rsp_rdata_r;
   assign bus.rsp_last  = rsp_last_r;
   assign bus.rsp_err   = rsp_err_r;

   // Burst sequencer: state, address walk and remaining-beat count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= S_IDLE;
         cur_addr_r   <= 32'h0000_0000;
         stride_r     <= 32'h0000_0000;
         rem_r        <= '0;
         err_sticky_r <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (req_fire_s) begin
                  state_r      <= bus.req_we ? S_STORE : S_LOAD;
                  cur_addr_r   <= bus.req_addr & 32'hFFFF_FFFC;
                  stride_r     <= bus.req_stride;
                  rem_r        <= (bus.req_count == CNT_W'(0)) ? CNT_W'(1) : bus.req_count;
                  err_sticky_r <= 1'b0;
               end
            end
            S_LOAD: begin
               if (ld_beat_s) begin
                  cur_addr_r <= cur_addr_r + stride_r;
                  rem_r      <= rem_r - CNT_W'(1);
                  if (last_s) begin
                     state_r <= S_IDLE;
                  end
               end
            end
            S_STORE: begin
               if (st_beat_s) begin
                  cur_addr_r   <= cur_addr_r + stride_r;
                  rem_r        <= rem_r - CNT_W'(1);
                  err_sticky_r <= err_sticky_r | oob_s;
                  if (last_s) begin
                     state_r <= S_ACK;
                  end
               end
            end
            S_ACK: begin
               if (ack_fire_s) begin
                  state_r <= S_IDLE;
               end
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   // Response register: load beats and store acks, held under backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= '0;
         rsp_last_r  <= 1'b0;
         rsp_err_r   <= 1'b0;
      end else if (ld_beat_s) begin
         rsp_valid_r <= 1'b1;
         rsp_rdata_r <= oob_s ? '0 : bus.mem_RD;
         rsp_last_r  <= last_s;
         rsp_err_r   <= oob_s;
      end else if (ack_fire_s) begin
         rsp_valid_r <= 1'b1;
         rsp_rdata_r <= '0;
         rsp_last_r  <= 1'b1;
         rsp_err_r   <= err_sticky_r;
      end else if (req_fire_s) begin
         rsp_err_r <= 1'b0;
      end else if (bus.rsp_ready) begin
         rsp_valid_r <= 1'b0;
      end else begin
         rsp_valid_r <= rsp_valid_r;
      end
   end
endmodule

// File: tb/tb_vec_mem_lsu.sv
// Directed testbench for vec_mem_lsu with a behavioural data_mem_vect model.
// Build with VEC_MEM_LSU_BOUNDS_CHECK_EN to add the bounds-check vectors (MEM_BYTES=16).
module tb_vec_mem_lsu;
`ifdef VEC_MEM_LSU_BOUNDS_CHECK_EN
   localparam int MB = 16;
`else
   localparam int MB = 1024;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   vec_mem_lsu_if #(.LANES(6), .EW(8), .CNT_W(4)) bus ();

`ifdef VEC_MEM_LSU_BOUNDS_CHECK_EN
   vec_mem_lsu #(.LANES(6), .EW(8), .CNT_W(4), .MEM_BYTES(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave));
`else
   vec_mem_lsu #(.LANES(6), .EW(8), .CNT_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave));
`endif

   always #5 clk = ~clk;

   // Memory model: unwritten words read back a fixed address-derived pattern
   logic [47:0] mem [0:255];
   bit          written [0:255];

   function automatic logic [47:0] pat(input int idx);
      logic [7:0] b;
      b = 8'(idx) ^ 8'hA5;
      return {b, b, b, b, b, b};
   endfunction

   always @(posedge clk) begin
      if (bus.mem_WE) begin
         mem[bus.mem_A[9:2]]     <= bus.mem_WD;
         written[bus.mem_A[9:2]] <= 1'b1;
      end
   end

   assign bus.mem_RD = written[bus.mem_A[9:2]] ? mem[bus.mem_A[9:2]] : pat(int'(bus.mem_A[9:2]));

   // Expected memory contents, updated only by the bench's own bookkeeping
   logic [47:0] exp_mem [0:255];

   function automatic logic exp_oob(input logic [31:0] a);
      return (a >= 32'(MB));
   endfunction

   function automatic logic [47:0] exp_rd(input logic [31:0] a);
      return exp_oob(a) ? 48'h0 : exp_mem[a[9:2]];
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] stride,
                           input logic [3:0] cnt);
      int n;
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_addr   = addr;
      bus.req_stride = stride;
      bus.req_count  = cnt;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.rsp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(bus.rsp_valid), 64'd1);
   endtask

   task automatic load_check(input logic [31:0] addr, input logic [31:0] stride, input int cnt);
      logic [31:0] a;
      a = addr;
      bus.rsp_ready = 1'b1;
      send_req(1'b0, addr, stride, 4'(cnt));
      for (int b = 0; b < cnt; b++) begin
         wait_rsp("ld_valid");
         chk("ld_rdata", 64'(bus.rsp_rdata), 64'(exp_rd(a)));
         chk("ld_last", 64'(bus.rsp_last), 64'(b == cnt - 1));
         chk("ld_err", 64'(bus.rsp_err), 64'(exp_oob(a)));
         a = a + stride;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) exp_mem[i] = pat(i);
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'h0;
      bus.req_stride = 32'h0; bus.req_count = 4'h0;
      bus.st_valid = 1'b0; bus.st_data = 48'h0; bus.rsp_ready = 1'b1;

      // Reset values
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mem_WE", 64'(bus.mem_WE), 64'd0);
      chk("rst_mem_A", 64'(bus.mem_A), 64'd0);
      chk("rst_mem_WD", 64'(bus.mem_WD), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_last", 64'(bus.rsp_last), 64'd0);
      chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
      chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      chk("rst_st_ready", 64'(bus.st_ready), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Test 1: single-beat store then read-back
      send_req(1'b1, 32'h0, 32'h4, 4'd1);
      bus.st_valid = 1'b1;
      bus.st_data  = 48'h00_11_22_33_44_55;
      @(negedge clk);
      chk("t1_we", 64'(bus.mem_WE), 64'd1);
      chk("t1_a", 64'(bus.mem_A), 64'h0);
      chk("t1_wd", 64'(bus.mem_WD), 64'h001122334455);
      chk("t1_st_ready", 64'(bus.st_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.st_valid = 1'b0;
      exp_mem[0] = 48'h00_11_22_33_44_55;
      @(negedge clk);
      chk("t1_we_after", 64'(bus.mem_WE), 64'd0);
      wait_rsp("t1_ack_valid");
      chk("t1_ack_last", 64'(bus.rsp_last), 64'd1);
      chk("t1_ack_rdata", 64'(bus.rsp_rdata), 64'd0);
      chk("t1_ack_err", 64'(bus.rsp_err), 64'd0);
      @(posedge clk);
      #1;
      load_check(32'h0, 32'h4, 1);

      // Test 2: five-beat load at full rate
      bus.rsp_ready = 1'b1;
      send_req(1'b0, 32'h0, 32'h4, 4'd5);
      for (int i = 0; i <= 5; i++) begin
         @(negedge clk);
         if (i < 5) chk("t2_addr", 64'(bus.mem_A), 64'(4 * i));
         if (i == 0) chk("t2_no_rsp_yet", 64'(bus.rsp_valid), 64'd0);
         if (i > 0) begin
            chk("t2_valid", 64'(bus.rsp_valid), 64'd1);
            chk("t2_rdata", 64'(bus.rsp_rdata), 64'(exp_rd(32'(4 * (i - 1)))));
            chk("t2_last", 64'(bus.rsp_last), 64'(i == 5));
            chk("t2_err", 64'(bus.rsp_err), 64'(exp_oob(32'(4 * (i - 1)))));
         end
         if (i == 5) chk("t2_req_ready_busy", 64'(bus.req_ready), 64'd0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("t2_drained", 64'(bus.rsp_valid), 64'd0);
      chk("t2_req_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      #1;

      // Test 3: backpressure on a three-beat load
      send_req(1'b0, 32'h0, 32'h4, 4'd3);
      @(negedge clk);
      chk("t3_addr0", 64'(bus.mem_A), 64'h0);
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t3_hold_valid", 64'(bus.rsp_valid), 64'd1);
         chk("t3_hold_rdata", 64'(bus.rsp_rdata), 64'(exp_rd(32'h0)));
         chk("t3_hold_addr", 64'(bus.mem_A), 64'h4);
         chk("t3_hold_req_ready", 64'(bus.req_ready), 64'd0);
         @(posedge clk);
         #1;
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("t3_beat0", 64'(bus.rsp_rdata), 64'(exp_rd(32'h0)));
      chk("t3_beat0_last", 64'(bus.rsp_last), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t3_beat1", 64'(bus.rsp_rdata), 64'(exp_rd(32'h4)));
      chk("t3_beat1_last", 64'(bus.rsp_last), 64'd0);
      chk("t3_addr2", 64'(bus.mem_A), 64'h8);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t3_beat2", 64'(bus.rsp_rdata), 64'(exp_rd(32'h8)));
      chk("t3_beat2_last", 64'(bus.rsp_last), 64'd1);
      chk("t3_req_ready_busy", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t3_drained", 64'(bus.rsp_valid), 64'd0);
      chk("t3_req_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      #1;

      // Test 4: two-beat store with bubbles
      send_req(1'b1, 32'h8, 32'h4, 4'd2);
      bus.st_valid = 1'b1;
      bus.st_data  = 48'hA1A2A3A4A5A6;
      @(negedge clk);
      chk("t4_we0", 64'(bus.mem_WE), 64'd1);
      chk("t4_a0", 64'(bus.mem_A), 64'h8);
      @(posedge clk);
      #1;
      bus.st_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("t4_bubble_we", 64'(bus.mem_WE), 64'd0);
         chk("t4_bubble_a", 64'(bus.mem_A), 64'hC);
         @(posedge clk);
         #1;
      end
      bus.st_valid = 1'b1;
      bus.st_data  = 48'hB1B2B3B4B5B6;
      @(negedge clk);
      chk("t4_we1", 64'(bus.mem_WE), 64'd1);
      chk("t4_a1", 64'(bus.mem_A), 64'hC);
      chk("t4_no_early_ack", 64'(bus.rsp_valid), 64'd0);
      @(posedge clk);
      #1;
      bus.st_valid = 1'b0;
      exp_mem[2] = 48'hA1A2A3A4A5A6;
      exp_mem[3] = 48'hB1B2B3B4B5B6;
      wait_rsp("t4_ack_valid");
      chk("t4_ack_last", 64'(bus.rsp_last), 64'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t4_single_ack", 64'(bus.rsp_valid), 64'd0);
      @(posedge clk);
      #1;
      load_check(32'h8, 32'h4, 2);

      // Test 5: async reset mid-way through a four-beat store
      send_req(1'b1, 32'h0, 32'h4, 4'd4);
      bus.st_valid = 1'b1;
      bus.st_data  = 48'hC1C2C3C4C5C6;
      @(negedge clk);
      chk("t5_a0", 64'(bus.mem_A), 64'h0);
      @(posedge clk);
      #1;
      bus.st_data = 48'hD1D2D3D4D5D6;
      @(negedge clk);
      chk("t5_a1", 64'(bus.mem_A), 64'h4);
      @(posedge clk);
      #1;
      bus.st_data = 48'hE1E2E3E4E5E6;
      exp_mem[0] = 48'hC1C2C3C4C5C6;
      exp_mem[1] = 48'hD1D2D3D4D5D6;
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_we", 64'(bus.mem_WE), 64'd0);
      chk("t5_rst_a", 64'(bus.mem_A), 64'd0);
      chk("t5_rst_st_ready", 64'(bus.st_ready), 64'd0);
      @(negedge clk);
      bus.st_valid = 1'b0;
      #2 rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t5_no_ack", 64'(bus.rsp_valid), 64'd0);
         chk("t5_req_ready", 64'(bus.req_ready), 64'd1);
      end
      @(posedge clk);
      #1;
      load_check(32'h0, 32'h4, 4);

`ifdef VEC_MEM_LSU_BOUNDS_CHECK_EN
      // Test 6: load straddling the bounds limit
      load_check(32'hC, 32'h4, 2);

      // Out-of-bounds store: write suppressed, ack flags the error
      send_req(1'b1, 32'h10, 32'h4, 4'd1);
      bus.st_valid = 1'b1;
      bus.st_data  = 48'hF1F2F3F4F5F6;
      @(negedge clk);
      chk("t6_oob_we", 64'(bus.mem_WE), 64'd0);
      chk("t6_oob_st_ready", 64'(bus.st_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.st_valid = 1'b0;
      wait_rsp("t6_ack_valid");
      chk("t6_ack_err", 64'(bus.rsp_err), 64'd1);
      chk("t6_ack_last", 64'(bus.rsp_last), 64'd1);
      @(posedge clk);
      #1;
      load_check(32'h0, 32'h4, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
